lab3_mem_refill_arbiter: RTL and testbench

Two-to-one memory arbiter that lets the instruction cache and data cache share a single 16B memory port. It sits between the two blocking caches' refill/evict ports and the test memory. It grants requests round-robin and records the winner of each accepted request in an in-order tag FIFO, so it can return each response to the cache that issued it. Both paths are combinational pass-through: the arbiter adds no cycles of latency.

---
 rtl/lab3_mem_refill_arbiter.sv | 109 ++++++++++
 tb/tb_lab3_mem_refill_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_mem_refill_arbiter.sv
// Round-robin 2:1 arbiter sharing one memory port between icache and dcache.
// Each accepted request's owner is queued in an in-order tag FIFO to route responses back.
module lab3_mem_refill_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int REQ_W           = 175,
    parameter int RESP_W          = 145,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1),
    localparam int PTR_W          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQ_W-1:0]  imemreq_msg,
    input  logic              imemreq_val,
    output logic              imemreq_rdy,
    output logic [RESP_W-1:0] imemresp_msg,
    output logic              imemresp_val,
    input  logic              imemresp_rdy,
    input  logic [REQ_W-1:0]  dmemreq_msg,
    input  logic              dmemreq_val,
    output logic              dmemreq_rdy,
    output logic [RESP_W-1:0] dmemresp_msg,
    output logic              dmemresp_val,
    input  logic              dmemresp_rdy,
    output logic [REQ_W-1:0]  memreq_msg,
    output logic              memreq_val,
    input  logic              memreq_rdy,
    input  logic [RESP_W-1:0] memresp_msg,
    input  logic              memresp_val,
    output logic              memresp_rdy,
    output logic [CNT_W-1:0]  outstanding
);

    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       last_grant_q, last_grant_d;
    logic                       full, empty, gnt_i, gnt_d, head_tag;
    logic                       req_fire, resp_fire;

    // Pointers wrap at the FIFO depth, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full     = (count_q == CNT_W'(MAX_OUTSTANDING));
        empty    = (count_q == '0);
        gnt_i    = imemreq_val & (~dmemreq_val | last_grant_q);
        gnt_d    = dmemreq_val & (~imemreq_val | ~last_grant_q);
        head_tag = fifo_q[head_q];
    end

    // Outputs are gated by reset so nothing handshakes while it is held low.
    always_comb begin
        memreq_val   = reset & (imemreq_val | dmemreq_val) & ~full;
        memreq_msg   = gnt_d ? dmemreq_msg : imemreq_msg;
        imemreq_rdy  = reset & gnt_i & memreq_rdy & ~full;
        dmemreq_rdy  = reset & gnt_d & memreq_rdy & ~full;
        imemresp_msg = memresp_msg;
        dmemresp_msg = memresp_msg;
        imemresp_val = reset & memresp_val & ~empty & ~head_tag;
        dmemresp_val = reset & memresp_val & ~empty & head_tag;
        memresp_rdy  = reset & ~empty & (head_tag ? dmemresp_rdy : imemresp_rdy);
        outstanding  = count_q;
        req_fire     = memreq_val & memreq_rdy;
        resp_fire    = memresp_val & memresp_rdy;
    end

    always_comb begin
        fifo_d       = fifo_q;
        tail_d       = tail_q;
        head_d       = head_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        if (req_fire) begin
            fifo_d[tail_q] = gnt_d;
            tail_d         = ptr_inc(tail_q);
            last_grant_d   = gnt_d;
        end
        if (resp_fire) begin
            head_d = ptr_inc(head_q);
        end
        case ({req_fire, resp_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Tag contents are meaningless once count is cleared, so they carry no reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_lab3_mem_refill_arbiter.sv
// Bench for lab3_mem_refill_arbiter: directed scenarios on a depth-2 instance and a
// randomized queue-model run on a depth-4 instance.
module tb_lab3_mem_refill_arbiter;

    localparam int REQ_W  = 175;
    localparam int RESP_W = 145;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // depth-2 instance
    logic [REQ_W-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
    logic [RESP_W-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
    logic imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
    logic dmemreq_val, dmemreq_rdy, dmemresp_val, dmemresp_rdy;
    logic memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic [1:0] outstanding;

    // depth-4 instance
    logic [REQ_W-1:0]  imemreq_msg_b, dmemreq_msg_b, memreq_msg_b;
    logic [RESP_W-1:0] imemresp_msg_b, dmemresp_msg_b, memresp_msg_b;
    logic imemreq_val_b, imemreq_rdy_b, imemresp_val_b, imemresp_rdy_b;
    logic dmemreq_val_b, dmemreq_rdy_b, dmemresp_val_b, dmemresp_rdy_b;
    logic memreq_val_b, memreq_rdy_b, memresp_val_b, memresp_rdy_b;
    logic [2:0] outstanding_b;

    lab3_mem_refill_arbiter #(.MAX_OUTSTANDING(2)) u_dut (
        .clk(clk), .reset(reset),
        .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
        .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
        .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
        .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .outstanding(outstanding)
    );

    lab3_mem_refill_arbiter #(.MAX_OUTSTANDING(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .imemreq_msg(imemreq_msg_b), .imemreq_val(imemreq_val_b), .imemreq_rdy(imemreq_rdy_b),
        .imemresp_msg(imemresp_msg_b), .imemresp_val(imemresp_val_b), .imemresp_rdy(imemresp_rdy_b),
        .dmemreq_msg(dmemreq_msg_b), .dmemreq_val(dmemreq_val_b), .dmemreq_rdy(dmemreq_rdy_b),
        .dmemresp_msg(dmemresp_msg_b), .dmemresp_val(dmemresp_val_b), .dmemresp_rdy(dmemresp_rdy_b),
        .memreq_msg(memreq_msg_b), .memreq_val(memreq_val_b), .memreq_rdy(memreq_rdy_b),
        .memresp_msg(memresp_msg_b), .memresp_val(memresp_val_b), .memresp_rdy(memresp_rdy_b),
        .outstanding(outstanding_b)
    );

    function automatic logic [REQ_W-1:0] mk_req(input logic [7:0] opq, input logic [31:0] addr,
                                                 input logic [127:0] data);
        return {3'd0, opq, addr, 4'd0, data};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(input logic [7:0] opq, input logic [127:0] data);
        return {3'd0, opq, 2'd0, 4'd0, data};
    endfunction

    function automatic logic [REQ_W-1:0] rnd_req();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[REQ_W-1:0];
    endfunction

    function automatic logic [RESP_W-1:0] rnd_resp();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[RESP_W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        imemreq_val = 0; dmemreq_val = 0; memreq_rdy = 0; memresp_val = 0;
        imemresp_rdy = 0; dmemresp_rdy = 0;
        imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0;
        imemreq_val_b = 0; dmemreq_val_b = 0; memreq_rdy_b = 0; memresp_val_b = 0;
        imemresp_rdy_b = 0; dmemresp_rdy_b = 0;
        imemreq_msg_b = '0; dmemreq_msg_b = '0; memresp_msg_b = '0;
    endtask

    task automatic test_reset();
        reset = 0;
        imemreq_val = 1; dmemreq_val = 1; memreq_rdy = 1; memresp_val = 1;
        imemresp_rdy = 1; dmemresp_rdy = 1;
        repeat (2) step();
        #1;
        checks++;
        if ({memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val, memresp_rdy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_vals: got %b want 000000",
                     {memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val, memresp_rdy});
        end
        checks++;
        if (outstanding !== 2'd0) begin
            errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
        end
        idle();
        step();
        reset = 1;
        step();
    endtask

    task automatic test_single_icache();
        logic [REQ_W-1:0]  rq;
        logic [RESP_W-1:0] rs;
        memresp_msg = rnd_resp();
        memresp_val = 1;
        #1;
        checks++;
        if ({memresp_rdy, imemresp_val, dmemresp_val} !== 3'b000) begin
            errors++; $display("FAIL empty_stall: got %b want 000", {memresp_rdy, imemresp_val, dmemresp_val});
        end
        memresp_val = 0;
        rq = mk_req(8'h05, 32'h0000_1000, 128'h0);
        imemreq_msg = rq; imemreq_val = 1; memreq_rdy = 1;
        #1;
        checks++;
        if ({memreq_val, imemreq_rdy, dmemreq_rdy} !== 3'b110) begin
            errors++; $display("FAIL single_req_hs: got %b want 110", {memreq_val, imemreq_rdy, dmemreq_rdy});
        end
        checks++;
        if (memreq_msg !== rq) begin
            errors++; $display("FAIL single_req_msg: got %h want %h", memreq_msg, rq);
        end
        checks++;
        if (outstanding !== 2'd0) begin
            errors++; $display("FAIL single_out0: got %0d want 0", outstanding);
        end
        step();
        imemreq_val = 0;
        #1;
        checks++;
        if (outstanding !== 2'd1 || memreq_val !== 1'b0) begin
            errors++; $display("FAIL single_out1: got %0d/%b want 1/0", outstanding, memreq_val);
        end
        repeat (2) step();
        rs = mk_resp(8'h05, 128'hDEADBEEF);
        memresp_msg = rs; memresp_val = 1; imemresp_rdy = 1; dmemresp_rdy = 1;
        #1;
        checks++;
        if ({imemresp_val, dmemresp_val, memresp_rdy} !== 3'b101) begin
            errors++; $display("FAIL single_resp_route: got %b want 101", {imemresp_val, dmemresp_val, memresp_rdy});
        end
        checks++;
        if (imemresp_msg !== rs) begin
            errors++; $display("FAIL single_resp_msg: got %h want %h", imemresp_msg, rs);
        end
        step();
        memresp_val = 0;
        #1;
        checks++;
        if (outstanding !== 2'd0) begin
            errors++; $display("FAIL single_out_back: got %0d want 0", outstanding);
        end
        idle();
    endtask

    task automatic test_full();
        int acc = 0;
        imemreq_msg = rnd_req(); imemreq_val = 1; memreq_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (imemreq_rdy === 1'b1) acc++;
            step();
        end
        checks++;
        if (acc != 2) begin
            errors++; $display("FAIL full_accepted: got %0d want 2", acc);
        end
        #1;
        checks++;
        if ({memreq_val, imemreq_rdy} !== 2'b00 || outstanding !== 2'd2) begin
            errors++; $display("FAIL full_block: got val/rdy %b out %0d want 00 out 2",
                               {memreq_val, imemreq_rdy}, outstanding);
        end
    endtask

    task automatic test_full_pop();
        logic [REQ_W-1:0] dm;
        dm = rnd_req();
        imemreq_val = 0; dmemreq_val = 1; dmemreq_msg = dm; memreq_rdy = 1;
        memresp_msg = rnd_resp(); memresp_val = 1; imemresp_rdy = 1; dmemresp_rdy = 1;
        #1;
        checks++;
        if ({memreq_val, dmemreq_rdy, memresp_rdy, imemresp_val} !== 4'b0011) begin
            errors++; $display("FAIL full_pop_same_cycle: got %b want 0011",
                               {memreq_val, dmemreq_rdy, memresp_rdy, imemresp_val});
        end
        step();
        memresp_val = 0;
        #1;
        checks++;
        if (outstanding !== 2'd1 || {memreq_val, dmemreq_rdy} !== 2'b11 || memreq_msg !== dm) begin
            errors++; $display("FAIL full_pop_next: got out %0d val/rdy %b want out 1 val/rdy 11 (msg ok=%b)",
                               outstanding, {memreq_val, dmemreq_rdy}, memreq_msg === dm);
        end
        step();
        dmemreq_val = 0;
        #1;
        checks++;
        if (outstanding !== 2'd2) begin
            errors++; $display("FAIL full_pop_refill: got %0d want 2", outstanding);
        end
    endtask

    task automatic test_resp_stall();
        memresp_msg = rnd_resp(); memresp_val = 1; imemresp_rdy = 0; dmemresp_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({memresp_rdy, dmemresp_val, imemresp_val} !== 3'b001) begin
                errors++; $display("FAIL stall_cycle%0d: got %b want 001", i, {memresp_rdy, dmemresp_val, imemresp_val});
            end
            step();
        end
        #1;
        checks++;
        if (outstanding !== 2'd2) begin
            errors++; $display("FAIL stall_hold: got %0d want 2", outstanding);
        end
        imemresp_rdy = 1;
        #1;
        checks++;
        if (memresp_rdy !== 1'b1) begin
            errors++; $display("FAIL stall_release: got %b want 1", memresp_rdy);
        end
        step();
        #1;
        checks++;
        if ({dmemresp_val, imemresp_val, memresp_rdy} !== 3'b101 || dmemresp_msg !== memresp_msg) begin
            errors++; $display("FAIL stall_second_d: got %b want 101", {dmemresp_val, imemresp_val, memresp_rdy});
        end
        step();
        memresp_val = 0;
        #1;
        checks++;
        if (outstanding !== 2'd0) begin
            errors++; $display("FAIL stall_drain: got %0d want 0", outstanding);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [REQ_W-1:0] dm;
        memreq_rdy = 1; imemreq_msg = rnd_req(); imemreq_val = 1;
        step();
        imemreq_val = 0; dmemreq_msg = rnd_req(); dmemreq_val = 1;
        step();
        dmemreq_val = 0;
        #1;
        checks++;
        if (outstanding !== 2'd2) begin
            errors++; $display("FAIL rstmid_setup: got %0d want 2", outstanding);
        end
        dm = rnd_req();
        imemreq_msg = rnd_req(); dmemreq_msg = dm;
        imemreq_val = 1; dmemreq_val = 1; memresp_val = 1; imemresp_rdy = 1; dmemresp_rdy = 1;
        #1;
        reset = 0;
        #1;
        checks++;
        if ({memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val, memresp_rdy} !== 6'b0
            || outstanding !== 2'd0) begin
            errors++; $display("FAIL rstmid_async: got %b out %0d want 000000 out 0",
                               {memreq_val, imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val, memresp_rdy},
                               outstanding);
        end
        step();
        reset = 1;
        memresp_val = 0;
        #1;
        checks++;
        if ({imemreq_rdy, dmemreq_rdy} !== 2'b01 || memreq_msg !== dm) begin
            errors++; $display("FAIL rstmid_dcache_first: got rdy i/d %b want 01 (msg ok=%b)",
                               {imemreq_rdy, dmemreq_rdy}, memreq_msg === dm);
        end
        idle();
        step();
    endtask

    // Depth-4 instance against a queue-of-owners model of the arbitration rules.
    task automatic test_random();
        bit q[$];
        bit lg = 0;
        int gi = 0, gd = 0;
        bit iv, dv, mr, mv, ir, dr, win_d, is_full, is_empty, hd, e_rv, e_rr, req_hs, resp_hs;
        logic [5:0] exp_v, obs_v;
        for (int c = 0; c < 400; c++) begin
            if (c < 120) begin
                iv = 1; dv = 1; mr = 1;
            end else begin
                iv = $urandom_range(0, 1) == 1; dv = $urandom_range(0, 1) == 1;
                mr = $urandom_range(0, 3) != 0;
            end
            mv = $urandom_range(0, 2) != 0;
            ir = $urandom_range(0, 3) != 0;
            dr = $urandom_range(0, 3) != 0;
            imemreq_val_b = iv; dmemreq_val_b = dv; memreq_rdy_b = mr;
            memresp_val_b = mv; imemresp_rdy_b = ir; dmemresp_rdy_b = dr;
            imemreq_msg_b = rnd_req(); dmemreq_msg_b = rnd_req(); memresp_msg_b = rnd_resp();
            #1;
            is_full  = (q.size() == 4);
            is_empty = (q.size() == 0);
            win_d    = dv && (!iv || !lg);
            hd       = is_empty ? 1'b0 : q[0];
            e_rv     = (iv || dv) && !is_full;
            e_rr     = !is_empty && (hd ? dr : ir);
            exp_v = {e_rv, iv && !win_d && mr && !is_full, win_d && mr && !is_full,
                     mv && !is_empty && !hd, mv && !is_empty && hd, e_rr};
            obs_v = {memreq_val_b, imemreq_rdy_b, dmemreq_rdy_b, imemresp_val_b, dmemresp_val_b, memresp_rdy_b};
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rand_ctrl c%0d: got %b want %b", c, obs_v, exp_v);
            end
            checks++;
            if (outstanding_b !== 3'(q.size())) begin
                errors++; $display("FAIL rand_outstanding c%0d: got %0d want %0d", c, outstanding_b, q.size());
            end
            if (e_rv) begin
                checks++;
                if (memreq_msg_b !== (win_d ? dmemreq_msg_b : imemreq_msg_b)) begin
                    errors++; $display("FAIL rand_reqmsg c%0d: got %h (winner d=%b)", c, memreq_msg_b, win_d);
                end
            end
            checks++;
            if (imemresp_msg_b !== memresp_msg_b || dmemresp_msg_b !== memresp_msg_b) begin
                errors++; $display("FAIL rand_broadcast c%0d: got %h/%h want %h",
                                   c, imemresp_msg_b, dmemresp_msg_b, memresp_msg_b);
            end
            req_hs  = e_rv && mr;
            resp_hs = mv && e_rr;
            if (resp_hs) void'(q.pop_front());
            if (req_hs) begin
                q.push_back(win_d);
                lg = win_d;
                if (win_d) gd++; else gi++;
            end
            step();
        end
        checks++;
        if (gi == 0 || gd == 0) begin
            errors++; $display("FAIL rand_starvation: got i=%0d d=%0d want both >0", gi, gd);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_icache();
        test_full();
        test_full_pop();
        test_resp_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
